// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline-control types and encodings for the hazard and forwarding units
package riscv_pipe_pkg;
  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} pipe_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: load-use stall, branch flush and MDU hold sequencer with watchdog and perf counters
module pipeline_ctrl #(
  parameter int CNT_W = 32,
  parameter int MDU_MAX_CYC = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MduReqE,
  input  logic             MduDone,
  output logic             MduGo,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MduErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  import riscv_pipe_pkg::*;
  localparam int WD_W = $clog2(MDU_MAX_CYC + 1);
  pipe_state_t state;
  logic [WD_W-1:0] wd;
  logic lw_stall, run, in_mdu, timeout, release_op, hold;
  assign lw_stall = ResultSrcE0 & RegWriteE & (RdE != REG_X0) & ((Rs1D == RdE) | (Rs2D == RdE));
  assign run = !reset && state == RUN;
  assign in_mdu = !reset && state == MDU_WAIT;
  assign timeout = in_mdu && wd == WD_W'(MDU_MAX_CYC - 1);
  assign release_op = MduDone | timeout;
  assign hold = in_mdu & !release_op;
  assign MduGo = run & MduReqE;
  assign StallF = (run & (lw_stall | MduReqE)) | hold;
  assign StallD = StallF;
  assign StallE = MduGo | hold;
  assign FlushM = StallE;
  assign FlushD = run & PCSrcE;
  assign FlushE = run & (lw_stall | PCSrcE);
  // A timeout releases the pipeline like a normal completion but latches the error
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      wd <= '0;
      MduErr <= 1'b0;
    end else if (state == RUN) begin
      if (MduReqE) begin
        state <= MDU_WAIT;
        wd <= '0;
      end
    end else if (release_op) begin
      state <= RUN;
      if (!MduDone) MduErr <= 1'b1;
    end else wd <= wd + 1'b1;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(StallF), .count(StallCount));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(FlushD), .count(FlushCount));
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a cycle-level reference model
module tb_pipeline_ctrl;
  localparam int CW = 4;
  localparam int MAXC = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdE = '0;
  logic RegWriteE = 1'b0, ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MduReqE = 1'b0, MduDone = 1'b0;
  logic MduGo, StallF, StallD, StallE, FlushD, FlushE, FlushM, MduErr;
  logic [CW-1:0] StallCount, FlushCount;
  int total = 0;
  int bad = 0;
  int busy = 0, waited = 0, err = 0, scnt = 0, fcnt = 0;

  pipeline_ctrl #(.CNT_W(CW), .MDU_MAX_CYC(MAXC)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MduReqE(MduReqE), .MduDone(MduDone), .MduGo(MduGo), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .MduErr(MduErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check outputs against the model, then advance the model at the edge
  task automatic step(input bit r, input int a, input int b, input int d,
                      input bit w, input bit l, input bit p, input bit q, input bit m);
    bit lw, fin;
    int go, sf, se, fd, fe;
    @(negedge clk);
    reset = r; Rs1D = 5'(a); Rs2D = 5'(b); RdE = 5'(d);
    RegWriteE = w; ResultSrcE0 = l; PCSrcE = p; MduReqE = q; MduDone = m;
    #1;
    lw = l && w && d != 0 && (a == d || b == d);
    fin = m || waited == MAXC - 1;
    go = 0; sf = 0; se = 0; fd = 0; fe = 0;
    if (!r && busy == 0) begin
      go = int'(q); sf = int'(lw || q); se = int'(q); fd = int'(p); fe = int'(lw || p);
    end else if (!r) begin
      sf = int'(!fin); se = int'(!fin);
    end
    chk("MduGo", int'(MduGo), go);
    chk("StallF", int'(StallF), sf);
    chk("StallD", int'(StallD), sf);
    chk("StallE", int'(StallE), se);
    chk("FlushM", int'(FlushM), se);
    chk("FlushD", int'(FlushD), fd);
    chk("FlushE", int'(FlushE), fe);
    chk("MduErr", int'(MduErr), err);
    chk("StallCount", int'(StallCount), scnt);
    chk("FlushCount", int'(FlushCount), fcnt);
    @(posedge clk);
    if (r) begin
      busy = 0; waited = 0; err = 0; scnt = 0; fcnt = 0;
    end else begin
      if (sf != 0 && scnt < CMAX) scnt++;
      if (fd != 0 && fcnt < CMAX) fcnt++;
      if (busy == 0) begin
        if (q) begin busy = 1; waited = 0; end
      end else if (fin) begin
        if (!m) err = 1;
        busy = 0;
      end else waited++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    #1 chk("reset_scnt", int'(StallCount), 0);
    chk("reset_fcnt", int'(FlushCount), 0);
    // load-use on rs1
    step(0, 5, 9, 5, 1, 1, 0, 0, 0);
    idle(1);
    #1 chk("lw_scnt", int'(StallCount), 1);
    // load to x0 never stalls
    do_reset();
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    #1 chk("x0_scnt", int'(StallCount), 0);
    // branch together with a load-use hazard on rs2
    do_reset();
    step(0, 3, 7, 7, 1, 1, 1, 0, 0);
    idle(1);
    #1 chk("br_fcnt", int'(FlushCount), 1);
    chk("br_scnt", int'(StallCount), 1);
    // MDU op completing after 5 cycles
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    #1 chk("mdu_scnt", int'(StallCount), 5);
    chk("mdu_err", int'(MduErr), 0);
    // watchdog timeout
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MAXC; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    #1 chk("wd_err", int'(MduErr), 1);
    chk("wd_scnt", int'(StallCount), MAXC);
    // reset during the third MDU_WAIT cycle
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_err", int'(MduErr), 0);
    chk("rst_scnt", int'(StallCount), 0);
    idle(2);
    // back-to-back MDU ops and an MduDone seen in RUN
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // saturation of both counters
    for (int i = 0; i < CMAX + 3; i++) step(0, 1, 2, 2, 1, 1, 1, 0, 0);
    #1 chk("sat_scnt", int'(StallCount), CMAX);
    chk("sat_fcnt", int'(FlushCount), CMAX);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
